// File: rtl/aes_text_loader.sv
// aes_text_loader: assembles four 32-bit plaintext words into a 128-bit block
// for aes_cipher_top and issues the single-cycle ld strobe. It then holds off
// further loads until the cipher signals done.
//
// Optional feature macro: AES_TEXT_LOADER_PREFETCH_EN
//   undefined : words are accepted only while idle (state FILL).
//   defined   : a 128-bit shadow buffer lets the next block be collected while
//               the cipher runs. On done it is loaded back-to-back.
//
// Ports:
//   clk      in   sole clock, rising edge
//   rst      in   asynchronous active-low reset
//   in_valid in   word-stream valid
//   in_ready out  word-stream ready (combinational from state/shadow only)
//   in_data  in   32-bit plaintext word, big-endian word order
//   in_last  in   marks word 3 of a block
//   ld       out  one-cycle load strobe to the cipher
//   text_in  out  assembled 128-bit block
//   done     in   cipher completion pulse
//   busy     out  high from the ld cycle until done is seen
//   err      out  sticky framing error
//   blk_cnt  out  count of completed blocks (wraps)
module aes_text_loader #(
   parameter int unsigned BLK_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_data,
   input  logic                 in_last,
   output logic                 ld,
   output logic [127:0]         text_in,
   input  logic                 done,
   output logic                 busy,
   output logic                 err,
   output logic [BLK_CNT_W-1:0] blk_cnt
);

   localparam int unsigned WORD_W = 32;
   localparam int unsigned BLK_W  = 128;
   localparam int unsigned ASM_W  = BLK_W - WORD_W;
   localparam int unsigned WCNT_W = 2;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      LOAD = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [WCNT_W-1:0]   wcnt_q;
   logic [ASM_W-1:0]    asm_q;
   logic                accept;
   logic                word3;
   logic                frame_abort;
   logic                load_direct;

`ifdef AES_TEXT_LOADER_PREFETCH_EN
   logic                shadow_full_q;
   logic [BLK_W-1:0]    shadow_q;
   logic                shadow_wr;
   logic                load_shadow;
`endif

   // Handshake decode and next-state logic
   always_comb begin
      state_d     = state_q;
      load_direct = 1'b0;
`ifdef AES_TEXT_LOADER_PREFETCH_EN
      shadow_wr   = 1'b0;
      load_shadow = 1'b0;
      in_ready    = (state_q == FILL) ? 1'b1 : !shadow_full_q;
`else
      in_ready    = (state_q == FILL);
`endif
      accept      = in_valid && in_ready;
      word3       = accept && (wcnt_q == WCNT_W'(3));
      frame_abort = accept && (wcnt_q != WCNT_W'(3)) && in_last;

      case (state_q)
         FILL: begin
            if (word3) begin
               state_d     = LOAD;
               load_direct = 1'b1;
            end
         end
         LOAD: begin
            state_d = WAIT;
`ifdef AES_TEXT_LOADER_PREFETCH_EN
            if (word3) shadow_wr = 1'b1;
`endif
         end
         WAIT: begin
            if (done) begin
`ifdef AES_TEXT_LOADER_PREFETCH_EN
               // A queued block restarts the cipher without passing through FILL
               if (shadow_full_q) begin
                  state_d     = LOAD;
                  load_shadow = 1'b1;
               end else if (word3) begin
                  state_d     = LOAD;
                  load_direct = 1'b1;
               end else begin
                  state_d = FILL;
               end
`else
               state_d = FILL;
`endif
            end
`ifdef AES_TEXT_LOADER_PREFETCH_EN
            else if (word3) begin
               shadow_wr = 1'b1;
            end
`endif
         end
         default: state_d = FILL;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= FILL;
      else      state_q <= state_d;
   end

   // Word counter and assembly register for words 0..2
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wcnt_q <= '0;
         asm_q  <= '0;
      end else begin
         if (frame_abort)  wcnt_q <= '0;
         else if (accept)  wcnt_q <= wcnt_q + WCNT_W'(1);
         if (accept && !word3) begin
            case (wcnt_q)
               2'd0:    asm_q[95:64] <= in_data;
               2'd1:    asm_q[63:32] <= in_data;
               2'd2:    asm_q[31:0]  <= in_data;
               default: asm_q        <= asm_q;
            endcase
         end
      end
   end

   // Cipher-facing outputs; text_in changes only when a new ld is issued
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         text_in <= '0;
         ld      <= 1'b0;
         busy    <= 1'b0;
         err     <= 1'b0;
         blk_cnt <= '0;
      end else begin
`ifdef AES_TEXT_LOADER_PREFETCH_EN
         if (load_shadow)      text_in <= shadow_q;
         else if (load_direct) text_in <= {asm_q, in_data};
`else
         if (load_direct)      text_in <= {asm_q, in_data};
`endif
         ld   <= (state_d == LOAD);
         busy <= (state_d != FILL);
         if (frame_abort || (word3 && !in_last)) err <= 1'b1;
         if ((state_q == WAIT) && done) blk_cnt <= blk_cnt + BLK_CNT_W'(1);
      end
   end

`ifdef AES_TEXT_LOADER_PREFETCH_EN
   // Shadow block collected while the cipher is running
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow_q      <= '0;
         shadow_full_q <= 1'b0;
      end else if (shadow_wr) begin
         shadow_q      <= {asm_q, in_data};
         shadow_full_q <= 1'b1;
      end else if (load_shadow) begin
         shadow_full_q <= 1'b0;
      end
   end
`endif

endmodule
